// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the decoder.
package cpu_pkg;

    localparam int ROM_SIZE = 256;
    localparam int ADDR_W   = $clog2(ROM_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_INC,
        NPC_ABS,
        NPC_REL
    } npc_sel_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection with ROM range check.
module next_pc_calc #(
    parameter int addr_w   = cpu_pkg::ADDR_W,
    parameter int rom_size = cpu_pkg::ROM_SIZE
) (
    input  logic [addr_w-1:0] pc,
    input  cpu_pkg::npc_sel_e sel,
    input  logic [addr_w-1:0] branch_target,
    output logic [addr_w-1:0] next_pc,
    output logic              out_of_range
);
    import cpu_pkg::*;

    localparam logic [addr_w-1:0] LIMIT = addr_w'(rom_size);

    always_comb begin
        next_pc = pc;
        case (sel)
            NPC_INC:  next_pc = pc + addr_w'(1);
            NPC_ABS:  next_pc = branch_target;
            // Offset is already full width, so the add wraps modulo 2^addr_w.
            NPC_REL:  next_pc = pc + branch_target;
            default:  next_pc = pc;
        endcase
    end

    assign out_of_range = (sel != NPC_HOLD) && (next_pc >= LIMIT);

endmodule

// File: rtl/fetch_pc.sv
// Program counter and run sequencer in front of the instruction ROM.
//   state | meaning
//   IDLE  | waiting for start, pc holds
//   RUN   | fetching; pc advances, branches or holds each cycle
//   DONE  | one-cycle end-of-run pulse, then back to IDLE
module fetch_pc #(
    parameter  int rom_size   = cpu_pkg::ROM_SIZE,
    parameter  int start_addr = 0,
    parameter  int cnt_width  = 16,
    localparam int ADDR_W     = $clog2(rom_size) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 branch_en,
    input  logic                 branch_rel,
    input  logic [ADDR_W-1:0]    branch_target,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [cnt_width-1:0] cycle_count
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(start_addr);

    state_e                 state, state_nx;
    npc_sel_e               sel;
    logic [ADDR_W-1:0]      npc, pc_nx;
    logic                   oor, fault_nx;
    logic [cnt_width-1:0]   cnt_nx;

    next_pc_calc #(
        .addr_w   (ADDR_W),
        .rom_size (rom_size)
    ) u_next_pc_calc (
        .pc            (pc),
        .sel           (sel),
        .branch_target (branch_target),
        .next_pc       (npc),
        .out_of_range  (oor)
    );

    // Kept apart from the FSM block so the select -> range-check path has no false loop.
    always_comb begin
        sel = NPC_HOLD;
        if (state == RUN && !stall && !halt) begin
            if (branch_en) sel = branch_rel ? NPC_REL : NPC_ABS;
            else           sel = NPC_INC;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        fault_nx = fault;
        cnt_nx   = cycle_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    pc_nx    = START_PC;
                    fault_nx = 1'b0;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (cycle_count != '1) cnt_nx = cycle_count + cnt_width'(1);
                if (!stall) begin
                    if (halt) begin
                        state_nx = DONE;
                    end else if (oor) begin
                        state_nx = DONE;
                        fault_nx = 1'b1;
                    end else begin
                        pc_nx = npc;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_PC;
            fault       <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            fault       <= fault_nx;
            cycle_count <= cnt_nx;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the instruction ROM.
- Drives the ROM address every cycle and advances it sequentially, or redirects it on branches reported by the decoder.
- Controls a program run through a start/done handshake with the testbench or top level.
- Flags out-of-range fetches and counts executed cycles for performance reporting.

Parameters:
- rom_size, 256, number of instruction words in the ROM; must match the ROM instance.
- start_addr, 0, PC value loaded on start.
- cnt_width, 16, width of the cycle counter.
- Derived localparam ADDR_W = $clog2(rom_size)+1. This matches the ROM address port width (9 bits at the default).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- stall  in  1  hold the PC for this cycle.
- halt  in  1  decoder reports that the current instruction is HALT.
- branch_en  in  1  decoder reports a taken branch for the current instruction.
- branch_rel  in  1  1 = branch_target is a signed offset from PC; 0 = absolute address.
- branch_target  in  ADDR_W  absolute address or two's-complement offset.
- pc  out  ADDR_W  current fetch address; connects to the ROM instr_addr.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a run ends.
- fault  out  1  sticky; set when a run ends because of an out-of-range PC.
- cycle_count  out  cnt_width  number of RUN cycles in the current or last run.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, pc=start_addr, busy=0, done=0, fault=0, cycle_count=0.
  - Reset wins over every other input, including mid-run.
- States:
  - IDLE: pc holds. When start=1 → RUN; load pc=start_addr, clear fault and cycle_count.
  - RUN: busy=1. cycle_count increments by 1 every RUN cycle, including stalled cycles, and saturates at all-ones. Next-PC is selected in this priority order:
    1. stall=1: pc holds; halt and branch are ignored this cycle.
    2. halt=1: → DONE; pc holds.
    3. branch_en=1, branch_rel=0: next = branch_target.
    4. branch_en=1, branch_rel=1: next = pc + sign-extended branch_target, computed modulo 2^ADDR_W.
    5. Otherwise: next = pc + 1.
  - Range check in RUN: if the candidate next is ≥ rom_size, go to DONE, set fault=1, and hold pc at its old value.
  - DONE: done=1 for exactly this one cycle, busy=0, then unconditionally → IDLE. A start asserted in DONE is ignored.
- start in RUN or DONE is ignored.
- Latency:
  - pc changes one cycle after the start, branch, or halt inputs are sampled.
  - The ROM is combinational, so the instruction for pc is valid in the same cycle.
- Wrap-around:
  - A relative branch that underflows past 0 wraps modulo 2^ADDR_W, then fails the range check and faults. It never silently wraps to a high valid address.
  - Sequential increment from rom_size-1 faults.
- After a run ends, cycle_count and fault hold until the next accepted start or reset.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the ROM size constant (256) and ADDR_W;
  - the next-PC select enum {NPC_HOLD, NPC_INC, NPC_ABS, NPC_REL}, which the decoder also uses.
- One sub-module is natural: next_pc_calc. It is combinational: it takes pc, the select signal, and branch_target, and returns the next address plus an out_of_range flag. The FSM and counters stay in fetch_pc.

Test Plan:
1. Reset then start, no branches, halt asserted at pc=5 → pc sequence 0,1,2,3,4,5; done pulses one cycle after halt is sampled; cycle_count=6; fault=0; busy low from the DONE cycle.
2. At pc=3, absolute branch to 10 → next pc=10. Then at pc=12, relative branch with offset 9'h1FC (−4) → pc=8.
3. stall held 3 cycles at pc=4 while halt=1 and branch_en=1 → pc stays 4 and no done. After stall drops with halt=1 → DONE, done=1.
4. Out-of-range cases: sequential increment at pc=255, and a relative −1 at pc=0 → each gives done=1, fault=1, pc held (255 and 0 respectively); a following start clears fault.
5. rst_n low for one cycle mid-run at pc=7 → next cycle pc=0, IDLE, busy=0, cycle_count=0, no done pulse. A start during RUN or DONE has no effect on pc.
